// File: rtl/mem_pkg.sv
// Shared types and constants for the data RAM responder.
// Holds the FSM state encoding and the default geometry.
package mem_pkg;

    localparam int AW_DEF = 9;
    localparam int DW_DEF = 16;
    localparam int DEPTH  = 1 << AW_DEF;

    typedef enum logic [2:0] {
        S_INIT,
        S_RUN,
        S_DBG,
        S_ACK,
        S_WAITLOW
    } mem_state_t;

    // States in which the memory-write stage owns the RAM port.
    function automatic logic pipe_owns_port(mem_state_t s);
        return (s == S_RUN) || (s == S_ACK) || (s == S_WAITLOW);
    endfunction

endpackage

// File: rtl/ram_1p.sv
// Single-port synchronous RAM with a registered, read-enabled output.
// The array is never reset; the responder's init sweep clears it.
module ram_1p #(
    parameter int AW = 9,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] r_mem [0:(1<<AW)-1];
    logic [DW-1:0] r_q;

    always_ff @(posedge clk) begin
        if (we) r_mem[addr] <= wdata;
        if (re) r_q <= r_mem[addr];
    end

    assign rdata = r_q;

endmodule

// File: rtl/data_ram_responder.sv
// Memory-side responder: owns the data RAM, zero-fills it after reset and
// arbitrates a four-phase debug port against the pipeline's load/store stage.
module data_ram_responder
    import mem_pkg::*;
#(
    parameter int AW        = AW_DEF,
    parameter int DW        = DW_DEF,
    parameter int INIT_ZERO = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          write_mem,
    input  logic          read_mem,
    input  logic [AW-1:0] addr_mem,
    input  logic [DW-1:0] wdata_mem,
    output logic [DW-1:0] rdata,
    output logic          rdata_valid,
    output logic          stall,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_ack,
    output logic [DW-1:0] dbg_rdata
);

    localparam logic [AW-1:0] LAST_ADDR = '1;

    mem_state_t    r_state, w_next;
    logic [AW-1:0] r_cnt;
    logic          r_rd_vld;
    logic [DW-1:0] r_rd_hold;
    logic          r_dbg_rd;
    logic [DW-1:0] r_dbg_hold;

    logic          w_pipe_ok, w_pipe_wr, w_pipe_rd;
    logic          w_we, w_re;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_wdata;
    logic [DW-1:0] w_ram_q;

    // A simultaneous store+load keeps the store and drops the load.
    assign w_pipe_ok = pipe_owns_port(r_state);
    assign w_pipe_wr = w_pipe_ok & write_mem;
    assign w_pipe_rd = w_pipe_ok & read_mem & ~write_mem;

    always_comb begin
        w_we    = 1'b0;
        w_re    = 1'b0;
        w_addr  = addr_mem;
        w_wdata = wdata_mem;
        case (r_state)
            S_INIT: begin
                w_we    = (INIT_ZERO != 0);
                w_addr  = r_cnt;
                w_wdata = '0;
            end
            S_DBG: begin
                w_we    = dbg_we;
                w_re    = ~dbg_we;
                w_addr  = dbg_addr;
                w_wdata = dbg_wdata;
            end
            default: begin
                w_we = w_pipe_wr;
                w_re = w_pipe_rd;
            end
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_INIT:    if (INIT_ZERO == 0 || r_cnt == LAST_ADDR) w_next = S_RUN;
            S_RUN:     if (dbg_req) w_next = S_DBG;
            S_DBG:     w_next = S_ACK;
            S_ACK:     w_next = S_WAITLOW;
            S_WAITLOW: if (!dbg_req) w_next = S_RUN;
            default:   w_next = S_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_INIT;
            r_cnt      <= '0;
            r_rd_vld   <= 1'b0;
            r_rd_hold  <= '0;
            r_dbg_rd   <= 1'b0;
            r_dbg_hold <= '0;
        end else begin
            r_state    <= w_next;
            if (r_state == S_INIT) r_cnt <= r_cnt + 1'b1;
            r_rd_vld   <= w_pipe_rd;
            r_rd_hold  <= rdata;
            r_dbg_rd   <= (r_state == S_DBG) && !dbg_we;
            r_dbg_hold <= dbg_rdata;
        end
    end

    ram_1p #(.AW(AW), .DW(DW)) u_ram (
        .clk   (clk),
        .we    (w_we),
        .re    (w_re),
        .addr  (w_addr),
        .wdata (w_wdata),
        .rdata (w_ram_q)
    );

    // The RAM output register is shared by both readers, so each output shows
    // it only in the cycle its own read lands and otherwise replays a hold copy.
    assign rdata       = r_rd_vld ? w_ram_q : r_rd_hold;
    assign rdata_valid = r_rd_vld;
    assign dbg_rdata   = r_dbg_rd ? w_ram_q : r_dbg_hold;
    assign dbg_ack     = (r_state == S_ACK);
    assign stall       = (r_state == S_INIT) || (r_state == S_DBG);

endmodule

// File: tb/tb_data_ram_responder.sv
// Self-checking bench for data_ram_responder: directed scenarios plus random
// load/store traffic compared against an array-based reference of the RAM.
module tb_data_ram_responder;

    logic        clk;
    logic        rst;
    logic        write_mem, read_mem;
    logic [8:0]  addr_mem;
    logic [15:0] wdata_mem;
    logic [15:0] rdata;
    logic        rdata_valid, stall;
    logic        dbg_req, dbg_we;
    logic [8:0]  dbg_addr;
    logic [15:0] dbg_wdata;
    logic        dbg_ack;
    logic [15:0] dbg_rdata;

    data_ram_responder #(.AW(9), .DW(16), .INIT_ZERO(1)) dut (
        .clk(clk), .rst(rst),
        .write_mem(write_mem), .read_mem(read_mem),
        .addr_mem(addr_mem), .wdata_mem(wdata_mem),
        .rdata(rdata), .rdata_valid(rdata_valid), .stall(stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] mem [0:511];
    logic [15:0] exp_rdata;
    logic        exp_valid;
    logic [15:0] exp_dbg;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 512; i++) mem[i] = 16'h0000;
    endtask

    // Counts edges after reset release until stall drops; expects 512.
    task automatic sweep(input string tag);
        int n;
        bit ack_seen;
        n = 0;
        ack_seen = 0;
        while (stall === 1'b1 && n < 1000) begin
            @(posedge clk); #1;
            n++;
            if (dbg_ack !== 1'b0) ack_seen = 1;
        end
        check({tag, "_len"}, n, 512);
        check({tag, "_noack"}, ack_seen, 0);
    endtask

    // One pipeline request, presented for exactly one cycle.
    task automatic pipe(input bit w, input bit r, input logic [8:0] a, input logic [15:0] d);
        write_mem = w; read_mem = r; addr_mem = a; wdata_mem = d;
        @(posedge clk); #1;
        if (w) mem[a] = d;
        if (r && !w) begin
            exp_valid = 1'b1;
            exp_rdata = mem[a];
        end else begin
            exp_valid = 1'b0;
        end
        write_mem = 0; read_mem = 0;
        check("pipe_valid", rdata_valid, exp_valid);
        check("pipe_rdata", rdata, exp_rdata);
    endtask

    // Full debug handshake starting in a RUN cycle. Optionally a pipeline
    // request is raised in the stall cycle and held until it is accepted.
    task automatic dbg_txn(input bit we, input logic [8:0] a, input logic [15:0] wd,
                           input bit hold, input bit pw, input bit pr,
                           input logic [8:0] pa, input logic [15:0] pd);
        dbg_req = 1; dbg_we = we; dbg_addr = a; dbg_wdata = wd;
        check("dbg_pre_stall", stall, 0);
        @(posedge clk); #1;
        exp_valid = 1'b0;
        check("dbg_stall_hi", stall, 1);
        check("dbg_ack_early", dbg_ack, 0);
        check("dbg_valid_stall", rdata_valid, 0);
        if (hold) begin
            write_mem = pw; read_mem = pr; addr_mem = pa; wdata_mem = pd;
        end
        @(posedge clk); #1;
        if (we) mem[a] = wd;
        else exp_dbg = mem[a];
        check("dbg_ack", dbg_ack, 1);
        check("dbg_ack_stall", stall, 0);
        check("dbg_rdata", dbg_rdata, exp_dbg);
        check("dbg_hold_ignored", rdata_valid, 0);
        @(posedge clk); #1;
        if (hold && pw) mem[pa] = pd;
        if (hold && pr && !pw) begin
            exp_valid = 1'b1;
            exp_rdata = mem[pa];
        end
        write_mem = 0; read_mem = 0;
        check("dbg_ack_once", dbg_ack, 0);
        check("dbg_after_valid", rdata_valid, exp_valid);
        check("dbg_after_rdata", rdata, exp_rdata);
        check("dbg_rdata_hold", dbg_rdata, exp_dbg);
        repeat (2) begin
            @(posedge clk); #1;
            check("dbg_req_held_noack", dbg_ack, 0);
            check("dbg_req_held_nostall", stall, 0);
        end
        dbg_req = 0;
        @(posedge clk); #1;
        exp_valid = 1'b0;
        check("dbg_release_noack", dbg_ack, 0);
        check("dbg_rdata_final", dbg_rdata, exp_dbg);
    endtask

    initial begin
        write_mem = 0; read_mem = 0; addr_mem = '0; wdata_mem = '0;
        dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
        exp_rdata = '0; exp_valid = 0; exp_dbg = '0;
        clear_model();
        rst = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_stall", stall, 1);
        check("rst_rdata", rdata, 0);
        check("rst_valid", rdata_valid, 0);
        check("rst_ack", dbg_ack, 0);
        check("rst_dbg_rdata", dbg_rdata, 0);
        rst = 1;
        sweep("init");
        pipe(0, 1, 9'h1FF, 0);

        pipe(1, 0, 9'h0A5, 16'hBEEF);
        pipe(0, 1, 9'h0A5, 0);
        check("raw_beef", rdata, 16'hBEEF);

        pipe(1, 1, 9'h010, 16'h1234);
        check("both_drop", rdata_valid, 0);
        pipe(0, 0, 0, 0);
        pipe(0, 1, 9'h010, 0);
        check("both_store", rdata, 16'h1234);

        dbg_txn(1, 9'h100, 16'h00FF, 0, 0, 0, 0, 0);
        dbg_txn(0, 9'h100, 0, 0, 0, 0, 0, 0);
        check("dbg_read_00ff", dbg_rdata, 16'h00FF);
        pipe(0, 1, 9'h100, 0);

        pipe(1, 0, 9'h020, 16'h1111);
        dbg_txn(0, 9'h020, 0, 1, 1, 0, 9'h020, 16'h5555);
        check("held_store_not_early", dbg_rdata, 16'h1111);
        pipe(0, 1, 9'h020, 0);
        check("held_store_done", rdata, 16'h5555);

        dbg_txn(1, 9'h030, 16'hCAFE, 1, 0, 1, 9'h0A5, 0);

        for (int i = 0; i < 300; i++) begin
            logic [8:0]  a;
            logic [15:0] d;
            int          op;
            a  = ($urandom_range(0, 3) == 0) ? 9'($urandom) : 9'($urandom_range(0, 15));
            d  = 16'($urandom);
            op = $urandom_range(0, 3);
            pipe(op[0], op[1], a, d);
            if (i % 50 == 49)
                dbg_txn(1'($urandom), 9'($urandom_range(0, 15)), 16'($urandom),
                        1'($urandom), 1'($urandom), 1'($urandom),
                        9'($urandom_range(0, 15)), 16'($urandom));
        end

        dbg_req = 1; dbg_we = 0; dbg_addr = 9'h0A5;
        @(posedge clk); #1;
        check("mid_stall_dbg", stall, 1);
        rst = 0;
        #1;
        check("mid_rst_stall", stall, 1);
        check("mid_rst_ack", dbg_ack, 0);
        check("mid_rst_valid", rdata_valid, 0);
        check("mid_rst_rdata", rdata, 0);
        check("mid_rst_dbg_rdata", dbg_rdata, 0);
        @(posedge clk); #1;
        check("mid_rst_ack_hold", dbg_ack, 0);
        clear_model();
        exp_rdata = '0; exp_valid = 0; exp_dbg = '0;
        rst = 1;
        sweep("reinit");
        dbg_txn(0, 9'h0A5, 0, 0, 0, 0, 0, 0);
        check("reinit_dbg_zero", dbg_rdata, 0);
        pipe(0, 1, 9'h020, 0);
        pipe(0, 1, 9'h010, 0);
        pipe(0, 1, 9'h100, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_ram_responder.md
# data_ram_responder

Memory-side responder for the pipeline's memory-write stage: it owns the 512×16 data RAM and services that stage's per-cycle store and load requests. Loads return data to writeback after exactly one cycle. It zero-fills the RAM after reset and arbitrates a four-phase debug/loader port against the pipeline. The pipeline is stalled whenever the RAM port is taken by init or debug.

## Interface
Parameters:
- AW, 9, address width; depth is 2^AW words
- DW, 16, data width
- INIT_ZERO, 1, 1 = sweep zeros through every word after reset; 0 = skip the sweep

Ports:
- clk, in, 1, rising-edge clock, single clock domain
- rst, in, 1, reset; asynchronous, active-low
- write_mem, in, 1, store request from the memory-write stage
- read_mem, in, 1, load request from the memory-write stage
- addr_mem, in, AW, request word address
- wdata_mem, in, DW, store data
- rdata, out, DW, load data to writeback
- rdata_valid, out, 1, rdata carries the result of the load accepted on the previous edge
- stall, out, 1, pipeline must hold its stage-3 request; requests are ignored while this is high
- dbg_req, in, 1, debug request; held high until dbg_ack
- dbg_we, in, 1, debug write (1) or read (0); sampled with dbg_req
- dbg_addr, in, AW, debug address
- dbg_wdata, in, DW, debug write data
- dbg_ack, out, 1, one-cycle acknowledge
- dbg_rdata, out, DW, debug read data; valid while dbg_ack is high

## Operation
States: S_INIT, S_RUN, S_DBG, S_ACK, S_WAITLOW.
- **S_INIT** (reset state)
  - Counter writes 0 to address cnt on each cycle; cnt goes 0..2^AW−1.
  - After writing the last address, the next state is S_RUN.
  - If INIT_ZERO=0, the block moves to S_RUN on the first edge without writing.
  - stall=1 throughout.
- **S_RUN**
  - stall=0.
  - write_mem=1: write wdata_mem to addr_mem this edge.
  - read_mem=1 and write_mem=0: read addr_mem. rdata is registered on the next edge and rdata_valid=1 for one cycle.
  - Both asserted: the write is performed and the read is dropped (rdata_valid=0).
  - dbg_req=1: the pipeline access in this cycle still executes. Next state is S_DBG.
- **S_DBG** (one cycle)
  - stall=1 and pipeline inputs are ignored.
  - The RAM port performs the debug access. A write uses dbg_wdata. A read registers the RAM output into dbg_rdata.
  - Next state is S_ACK.
- **S_ACK** (one cycle)
  - dbg_ack=1, stall=0, and the pipeline is serviced as in S_RUN.
  - Next state is S_WAITLOW.
- **S_WAITLOW**
  - Pipeline is serviced as in S_RUN.
  - dbg_req=1 is ignored. When dbg_req=0, next state is S_RUN.
- rdata holds its last value until the next accepted load. rdata_valid is cleared on any cycle with no accepted load.
- dbg_rdata holds its value after ack. A debug write leaves dbg_rdata unchanged.
- Read-after-write to the same address on consecutive accepted requests returns the newly written data (write-first ordering).
- Addresses are AW bits wide, so there is no out-of-range case.

## Timing
- Load latency is 1 cycle: a load accepted at edge N gives rdata/rdata_valid after edge N.
- Store takes effect at the accepting edge.
- Debug latency from the first S_RUN cycle with dbg_req=1:
  - S_DBG follows 1 cycle later.
  - dbg_ack follows 2 cycles later.
  - The pipeline loses exactly one cycle (S_DBG).
- Init duration is 2^AW cycles of stall=1 (512 by default).
- Reset values (asynchronous, on rst=0):
  - state=S_INIT, cnt=0
  - rdata=0, rdata_valid=0, dbg_ack=0, dbg_rdata=0
  - stall=1
- Reset mid-operation:
  - All of the above are restored immediately.
  - Any in-flight load or debug transaction is abandoned with no ack.
  - RAM contents are not reset asynchronously; the init sweep re-zeros them.
- dbg_req rising during S_INIT is held off until S_RUN.

## Structure
- Package mem_pkg:
  - state enum mem_state_t
  - default AW/DW constants
  - DEPTH = 1<<AW
- Sub-module ram_1p:
  - single-port synchronous RAM: we, addr, wdata, registered rdata
  - no reset on the array
- Top-level contents: FSM, init counter, port mux (init / debug / pipeline), output registers.

## Test plan
- **Reset and init**
  - Stimulus: deassert rst, INIT_ZERO=1.
  - Response: stall=1 for 512 cycles, then 0. A load from 0x1FF returns 0x0000 with rdata_valid one cycle later.
- **Store then load**
  - Stimulus: store 0xBEEF to 0x0A5, then load 0x0A5 on the next cycle.
  - Response: rdata=0xBEEF and rdata_valid=1 exactly one cycle after the load.
- **Simultaneous write_mem and read_mem**
  - Stimulus: both asserted, addr 0x010, wdata 0x1234.
  - Response: rdata_valid=0, and a later load of 0x010 returns 0x1234.
- **Debug write then read**
  - Stimulus: debug write 0x00FF→0x100, then a debug read of 0x100.
  - Response: each transaction gives dbg_ack 2 cycles after dbg_req and stall high exactly 1 cycle. The read returns dbg_rdata=0x00FF. No new ack while dbg_req stays high.
- **Pipeline store held across a debug stall**
  - Stimulus: pipeline store 0x5555 to 0x020 held across the S_DBG cycle.
  - Response: the store is ignored during stall and executed once after. Final content at 0x020 is 0x5555.
- **Reset mid-transaction**
  - Stimulus: assert rst during S_DBG.
  - Response: dbg_ack never pulses, stall=1 immediately, and the init sweep restarts at cnt=0.
